// File: rtl/mem_access_stage.sv
// MIPS-R2000 MEM stage: runs loads/stores over a req/ack data-memory
// handshake and holds the front of the pipeline while a request is
// outstanding. Results are registered into MEM/WB. Misaligned and timed-out
// accesses are flagged with single-cycle pulses.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] res,
    input  logic [31:0] write_data_ex,
    input  logic [4:0]  write_register,
    input  logic        zero,
    input  logic [2:0]  m_MEM,
    input  logic [1:0]  wb_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] read_data_wb,
    output logic [31:0] res_wb,
    output logic [4:0]  write_register_wb,
    output logic [1:0]  wb_WB,
    output logic        exc_misaligned,
    output logic        exc_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0] readData_q;
    logic [31:0] res_q;
    logic [4:0]  writeReg_q;
    logic [1:0]  wb_q;

    logic memOp;
    logic aligned;
    logic timeoutHit;
    logic loadWb;

    assign memOp   = m_MEM[1] | m_MEM[0];
    assign aligned = (res[1:0] == 2'b00);

    // Last waiting cycle with no ack: the request is abandoned this cycle.
    assign timeoutHit = (state_q == S_WAIT) && !dmem_ack && (cnt_q == CNT_LAST);

    // State and timeout counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: enter WAIT when an aligned request misses its first-cycle ack.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (memOp && aligned && !dmem_ack) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            S_WAIT: begin
                if (dmem_ack || timeoutHit) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake, stall and exception outputs; all forced low while in reset.
    always_comb begin
        dmem_req       = rst_n && ((state_q == S_WAIT) || (memOp && aligned));
        dmem_we        = dmem_req && !m_MEM[1];
        dmem_addr      = dmem_req ? res : 32'h0;
        dmem_wdata     = dmem_req ? write_data_ex : 32'h0;
        stall          = dmem_req && !dmem_ack && !timeoutHit;
        exc_misaligned = rst_n && (state_q == S_IDLE) && memOp && !aligned;
        exc_timeout    = rst_n && timeoutHit;
        pc_src         = m_MEM[2] & zero;
        loadWb         = ((state_q == S_IDLE) && !memOp) || (dmem_req && dmem_ack);
    end

    // MEM/WB register: load on retirement, otherwise insert a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readData_q <= '0;
            res_q      <= '0;
            writeReg_q <= '0;
            wb_q       <= '0;
        end else if (loadWb) begin
            readData_q <= m_MEM[1] ? dmem_rdata : 32'h0;
            res_q      <= res;
            writeReg_q <= write_register;
            wb_q       <= wb_MEM;
        end else begin
            wb_q <= '0;
        end
    end

    assign read_data_wb      = readData_q;
    assign res_wb            = res_q;
    assign write_register_wb = writeReg_q;
    assign wb_WB             = wb_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a request-age model.
module tb_mem_access_stage;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst_n;
    logic [31:0] res;
    logic [31:0] write_data_ex;
    logic [4:0]  write_register;
    logic        zero;
    logic [2:0]  m_MEM;
    logic [1:0]  wb_MEM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall;
    logic        pc_src;
    logic [31:0] read_data_wb;
    logic [31:0] res_wb;
    logic [4:0]  write_register_wb;
    logic [1:0]  wb_WB;
    logic        exc_misaligned;
    logic        exc_timeout;

    int tests = 0;
    int fails = 0;

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .res(res),
        .write_data_ex(write_data_ex),
        .write_register(write_register),
        .zero(zero),
        .m_MEM(m_MEM),
        .wb_MEM(wb_MEM),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack),
        .stall(stall),
        .pc_src(pc_src),
        .read_data_wb(read_data_wb),
        .res_wb(res_wb),
        .write_register_wb(write_register_wb),
        .wb_WB(wb_WB),
        .exc_misaligned(exc_misaligned),
        .exc_timeout(exc_timeout)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: "waited" counts the cycles the current request has
    // already spent outstanding (0 = no request in flight).
    int          waited = 0;
    logic [31:0] expRd = '0;
    logic [31:0] expRes = '0;
    logic [4:0]  expWreg = '0;
    logic [1:0]  expWb = '0;
    logic        expStallLast = 1'b0;

    logic mMemOp, mAligned, mReq, mTimeout;
    assign mMemOp   = m_MEM[1] | m_MEM[0];
    assign mAligned = (res[1:0] == 2'b00);
    assign mReq     = (waited != 0) || (mMemOp && mAligned);
    assign mTimeout = (waited == TIMEOUT - 1) && !dmem_ack;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model advance: retire, bubble, or age the outstanding request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waited  = 0;
            expRd   = '0;
            expRes  = '0;
            expWreg = '0;
            expWb   = '0;
        end else if (waited == 0 && !mMemOp) begin
            expRd   = 32'h0;
            expRes  = res;
            expWreg = write_register;
            expWb   = wb_MEM;
        end else if (mReq && dmem_ack) begin
            expRd   = m_MEM[1] ? dmem_rdata : 32'h0;
            expRes  = res;
            expWreg = write_register;
            expWb   = wb_MEM;
            waited  = 0;
        end else begin
            expWb = 2'b00;
            if (waited != 0 && mTimeout) waited = 0;
            else if (mReq) waited = waited + 1;
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        logic eReq, eStall, eTo, eMis;
        eReq   = rst_n && mReq;
        eTo    = rst_n && (waited != 0) && mTimeout;
        eStall = eReq && !dmem_ack && !eTo;
        eMis   = rst_n && (waited == 0) && mMemOp && !mAligned;
        expStallLast = eStall;
        checkOutput("dmem_req", dmem_req, eReq);
        checkOutput("dmem_we", dmem_we, eReq && !m_MEM[1]);
        checkOutput("dmem_addr", dmem_addr, eReq ? res : 32'h0);
        checkOutput("dmem_wdata", dmem_wdata, eReq ? write_data_ex : 32'h0);
        checkOutput("stall", stall, eStall);
        checkOutput("exc_timeout", exc_timeout, eTo);
        checkOutput("exc_misaligned", exc_misaligned, eMis);
        checkOutput("pc_src", pc_src, m_MEM[2] & zero);
        checkOutput("read_data_wb", read_data_wb, expRd);
        checkOutput("res_wb", res_wb, expRes);
        checkOutput("write_register_wb", write_register_wb, expWreg);
        checkOutput("wb_WB", wb_WB, expWb);
    end

    task automatic applyStimulus(input logic [31:0] r, input logic [31:0] wd, input logic [4:0] wr,
                                 input logic z, input logic [2:0] m, input logic [1:0] wb,
                                 input logic ack, input logic [31:0] rd);
        res            = r;
        write_data_ex  = wd;
        write_register = wr;
        zero           = z;
        m_MEM          = m;
        wb_MEM         = wb;
        dmem_ack       = ack;
        dmem_rdata     = rd;
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(32'h0, 32'h0, 5'd0, 1'b0, 3'b000, 2'b00, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset res_wb", res_wb, 32'h0);
        checkOutput("reset wb_WB", wb_WB, 32'h0);
        checkOutput("reset dmem_req", dmem_req, 32'h0);
        checkOutput("reset stall", stall, 32'h0);
        rst_n = 1'b1;

        // ALU pass-through
        applyStimulus(32'h2A, 32'h0, 5'd5, 1'b0, 3'b000, 2'b01, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("alu stall", stall, 32'h0);
        nextEdge();
        checkOutput("alu res_wb", res_wb, 32'h2A);
        checkOutput("alu wreg", write_register_wb, 32'd5);
        checkOutput("alu wb_WB", wb_WB, 32'h1);

        // Zero-wait load
        applyStimulus(32'h100, 32'h0, 5'd7, 1'b0, 3'b010, 2'b11, 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("ld0 stall", stall, 32'h0);
        checkOutput("ld0 req", dmem_req, 32'h1);
        nextEdge();
        checkOutput("ld0 read_data_wb", read_data_wb, 32'hDEADBEEF);
        checkOutput("ld0 wb_WB", wb_WB, 32'h3);

        // Store acknowledged on its fourth cycle
        applyStimulus(32'h40, 32'h1234, 5'd0, 1'b0, 3'b001, 2'b10, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            @(negedge clk);
            checkOutput("st req", dmem_req, 32'h1);
            checkOutput("st we", dmem_we, 32'h1);
            checkOutput("st addr", dmem_addr, 32'h40);
            checkOutput("st wdata", dmem_wdata, 32'h1234);
            checkOutput("st stall", stall, (i < 3) ? 32'h1 : 32'h0);
            if (i > 0) checkOutput("st bubble", wb_WB, 32'h0);
            nextEdge();
        end
        checkOutput("st wb_WB", wb_WB, 32'h2);
        checkOutput("st res_wb", res_wb, 32'h40);
        checkOutput("st read_data_wb", read_data_wb, 32'h0);

        // Misaligned load, with a stray ack that must be ignored
        applyStimulus(32'h102, 32'h0, 5'd9, 1'b0, 3'b010, 2'b11, 1'b1, 32'h55);
        @(negedge clk);
        checkOutput("mis req", dmem_req, 32'h0);
        checkOutput("mis exc", exc_misaligned, 32'h1);
        checkOutput("mis stall", stall, 32'h0);
        nextEdge();
        checkOutput("mis wb_WB", wb_WB, 32'h0);

        // Never-acknowledged load times out on its 16th cycle
        applyStimulus(32'h200, 32'h0, 5'd3, 1'b0, 3'b010, 2'b11, 1'b0, 32'h0);
        for (int cyc = 1; cyc <= TIMEOUT; cyc++) begin
            @(negedge clk);
            checkOutput("to req", dmem_req, 32'h1);
            checkOutput("to exc", exc_timeout, (cyc == TIMEOUT) ? 32'h1 : 32'h0);
            checkOutput("to stall", stall, (cyc < TIMEOUT) ? 32'h1 : 32'h0);
            nextEdge();
        end
        checkOutput("to wb_WB", wb_WB, 32'h0);
        applyStimulus(32'h8, 32'h0, 5'd1, 1'b1, 3'b100, 2'b00, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("to req dropped", dmem_req, 32'h0);
        checkOutput("branch pc_src", pc_src, 32'h1);
        nextEdge();

        // Reset in the middle of a wait, then a clean load
        applyStimulus(32'h300, 32'h0, 5'd4, 1'b0, 3'b010, 2'b01, 1'b0, 32'h0);
        nextEdge();
        nextEdge();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst req", dmem_req, 32'h0);
        checkOutput("rst stall", stall, 32'h0);
        checkOutput("rst wb_WB", wb_WB, 32'h0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        nextEdge();
        checkOutput("post-rst read_data_wb", read_data_wb, 32'hCAFEF00D);
        checkOutput("post-rst wb_WB", wb_WB, 32'h1);

        // Randomized traffic; instruction held whenever the model says stall
        for (int n = 0; n < 3000; n++) begin
            if (!expStallLast) begin
                logic [31:0] r;
                logic [2:0]  m;
                int          kind;
                kind = $urandom_range(0, 9);
                r    = $urandom;
                m    = 3'b000;
                case (kind)
                    3, 4: m = 3'b010;
                    5, 6: m = 3'b001;
                    7: m = 3'b011;
                    8: m = 3'($urandom_range(1, 3));
                    9: m = 3'($urandom_range(4, 7));
                    default: m = 3'b000;
                endcase
                if (kind >= 3 && kind <= 7) r[1:0] = 2'b00;
                if (kind == 8 && r[1:0] == 2'b00) r[1:0] = 2'b01;
                res            = r;
                write_data_ex  = $urandom;
                write_register = 5'($urandom);
                zero           = 1'($urandom);
                m_MEM          = m;
                wb_MEM         = 2'($urandom);
            end
            dmem_ack   = ($urandom_range(0, 3) == 0);
            dmem_rdata = $urandom;
            nextEdge();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
